// File: rtl/arbiter_control_if.sv
// Request/response bundle between the two caches, physical memory and the arbiter FSM.
// master: the caches and memory side; slave: the arbiter.
interface arbiter_control_if;
    logic cache1_read;
    logic cache1_write;
    logic cache2_read;
    logic cache2_write;
    logic pmem_resp;
    logic cache1_resp;
    logic cache2_resp;
    logic pmem_read;
    logic pmem_write;
    logic cache_sel;

    // Requests are levels held until the matching cacheN_resp pulse; pmem_read/pmem_write
    // are levels held until the single-cycle pmem_resp pulse that completes the transfer.
    modport master (
        output cache1_read, cache1_write, cache2_read, cache2_write, pmem_resp,
        input  cache1_resp, cache2_resp, pmem_read, pmem_write, cache_sel
    );

    modport slave (
        input  cache1_read, cache1_write, cache2_read, cache2_write, pmem_resp,
        output cache1_resp, cache2_resp, pmem_read, pmem_write, cache_sel
    );
endinterface

// File: rtl/arbiter_control.sv
// Cache-to-physical-memory arbiter sequencing FSM: grants cache1 or cache2 one line transfer at a time.
// Tie rule selected by ARBITER_ROUND_ROBIN_EN (round robin when defined, cache1 priority otherwise).
module arbiter_control (
    input  logic                     clk,
    input  logic                     rst,
    arbiter_control_if.slave         bus,
    output logic [1:0]               state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   op_write_q, op_write_d;
    logic   last_served_q, last_served_d;

    logic req1;
    logic req2;
    logic grant2;

    assign req1 = bus.cache1_read | bus.cache1_write;
    assign req2 = bus.cache2_read | bus.cache2_write;

`ifdef ARBITER_ROUND_ROBIN_EN
    // On a tie, hand the grant to whichever cache was not served last.
    assign grant2 = req2 & (~req1 | ~last_served_q);
`else
    assign grant2 = req2 & ~req1;
`endif

    always_comb begin
        state_d         = state_q;
        op_write_d      = op_write_q;
        last_served_d   = last_served_q;
        bus.cache1_resp = 1'b0;
        bus.cache2_resp = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.cache_sel   = 1'b0;

        // Outputs are held low while reset is asserted, which also discards any pmem_resp.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req1 | req2) begin
                        state_d    = grant2 ? SERVE2 : SERVE1;
                        op_write_d = grant2 ? bus.cache2_write : bus.cache1_write;
                    end
                end
                SERVE1: begin
                    bus.pmem_write = op_write_q;
                    bus.pmem_read  = ~op_write_q;
                    if (bus.pmem_resp) begin
                        bus.cache1_resp = 1'b1;
                        last_served_d   = 1'b0;
                        state_d         = IDLE;
                    end
                end
                SERVE2: begin
                    bus.cache_sel  = 1'b1;
                    bus.pmem_write = op_write_q;
                    bus.pmem_read  = ~op_write_q;
                    if (bus.pmem_resp) begin
                        bus.cache2_resp = 1'b1;
                        last_served_d   = 1'b1;
                        state_d         = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_write_q    <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_write_q    <= op_write_d;
            last_served_q <= last_served_d;
        end
    end

    assign state_o = state_q;

endmodule
